// File: rtl/decode_register_file.sv
// decode_register_file: integer register file feeding the decode stage, with a
// load scoreboard that stalls decode while a consumed source awaits its load.
// Optional feature macro: REGFILE_BYPASS_EN (write-first forwarding from
// writeback to the read ports, and the stall is masked for the retiring register).
module decode_register_file #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int AW   = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   A1D,
  input  logic [AW-1:0]   A2D,
  input  logic            Use1D,
  input  logic            Use2D,
  output logic [XLEN-1:0] RD1D,
  output logic [XLEN-1:0] RD2D,
  input  logic            RegWriteW,
  input  logic [AW-1:0]   RdW,
  input  logic [XLEN-1:0] ResultW,
  input  logic            LoadIssueE,
  input  logic [AW-1:0]   RdE,
  input  logic            FlushE,
  output logic            StallD,
  output logic [NREG-1:0] BusyVec
);

  logic [XLEN-1:0] regFile [NREG];
  logic [NREG-1:0] busy;
  logic [NREG-1:0] busyNext;
  logic            writeValid;
  logic            loadValid;
  logic [XLEN-1:0] rd1;
  logic [XLEN-1:0] rd2;
  logic            busy1;
  logic            busy2;

  // x0 is never a real destination, so a write or load aimed at it does nothing.
  assign writeValid = RegWriteW && (RdW != '0);
  assign loadValid  = LoadIssueE && !FlushE && (RdE != '0);

`ifdef REGFILE_BYPASS_EN
  logic bypassOn;
  // Forwarding is disabled while reset is held so reads stay at zero.
  assign bypassOn = writeValid && rst;
`endif

  // Register storage: cleared on reset, written by writeback on the rising edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) begin
        regFile[i] <= '0;
      end
    end else if (writeValid) begin
      regFile[RdW] <= ResultW;
    end
  end

  // Scoreboard next state: retire first, then mark the new load, so a younger load wins.
  always_comb begin
    busyNext = busy;
    if (writeValid) begin
      busyNext[RdW] = 1'b0;
    end
    if (loadValid) begin
      busyNext[RdE] = 1'b1;
    end
    busyNext[0] = 1'b0;
  end

  // Scoreboard register; pending loads are forgotten on reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy <= '0;
    end else begin
      busy <= busyNext;
    end
  end

  // Read ports and per-port busy terms, with optional write-first forwarding.
  always_comb begin
    rd1   = regFile[A1D];
    rd2   = regFile[A2D];
    busy1 = busy[A1D];
    busy2 = busy[A2D];
`ifdef REGFILE_BYPASS_EN
    if (bypassOn && (RdW == A1D)) begin
      rd1   = ResultW;
      busy1 = 1'b0;
    end
    if (bypassOn && (RdW == A2D)) begin
      rd2   = ResultW;
      busy2 = 1'b0;
    end
`endif
    if (A1D == '0) begin
      rd1   = '0;
      busy1 = 1'b0;
    end
    if (A2D == '0) begin
      rd2   = '0;
      busy2 = 1'b0;
    end
  end

  assign RD1D    = rd1;
  assign RD2D    = rd2;
  assign StallD  = (Use1D && busy1) || (Use2D && busy2);
  assign BusyVec = busy;

endmodule

// File: tb/tb_decode_register_file.sv
// Testbench for decode_register_file: directed scenarios plus randomized traffic
// checked against a behavioural register/scoreboard model.
module tb_decode_register_file;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = 5;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic [AW-1:0]   A1D, A2D, RdW, RdE;
  logic            Use1D, Use2D, RegWriteW, LoadIssueE, FlushE;
  logic [XLEN-1:0] ResultW;
  logic [XLEN-1:0] RD1D, RD2D;
  logic            StallD;
  logic [NREG-1:0] BusyVec;

  int vectors     = 0;
  int miscompares = 0;

  logic [XLEN-1:0] mRegs [NREG];
  logic            mBusy [NREG];

  decode_register_file #(.XLEN(XLEN), .NREG(NREG), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .A1D(A1D), .A2D(A2D), .Use1D(Use1D), .Use2D(Use2D),
    .RD1D(RD1D), .RD2D(RD2D),
    .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW),
    .LoadIssueE(LoadIssueE), .RdE(RdE), .FlushE(FlushE),
    .StallD(StallD), .BusyVec(BusyVec)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: time limit reached, expected completion");
    $fatal(1, "[TB] timeout");
  end

  function automatic logic retiring(input logic [AW-1:0] a);
    return BYPASS && rst && RegWriteW && (RdW != 0) && (RdW == a);
  endfunction

  function automatic logic [XLEN-1:0] expRead(input logic [AW-1:0] a);
    if (a == 0) return '0;
    if (retiring(a)) return ResultW;
    return mRegs[a];
  endfunction

  function automatic logic expStall();
    logic s1, s2;
    s1 = Use1D && (A1D != 0) && mBusy[A1D] && !retiring(A1D);
    s2 = Use2D && (A2D != 0) && mBusy[A2D] && !retiring(A2D);
    return s1 || s2;
  endfunction

  function automatic logic [NREG-1:0] expBusyVec();
    logic [NREG-1:0] v;
    for (int i = 0; i < NREG; i++) v[i] = mBusy[i];
    return v;
  endfunction

  task automatic resetModel();
    for (int i = 0; i < NREG; i++) begin
      mRegs[i] = '0;
      mBusy[i] = 1'b0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) begin
      if (RegWriteW && RdW != 0) begin
        mRegs[RdW] = ResultW;
        mBusy[RdW] = 1'b0;
      end
      if (LoadIssueE && !FlushE && RdE != 0) mBusy[RdE] = 1'b1;
    end
    #1;
  endtask

  task automatic applyStimulus(input logic wr, input logic [AW-1:0] rdw, input logic [XLEN-1:0] res,
                               input logic ld, input logic [AW-1:0] rde, input logic fl);
    RegWriteW  = wr;
    RdW        = rdw;
    ResultW    = res;
    LoadIssueE = ld;
    RdE        = rde;
    FlushE     = fl;
  endtask

  task automatic applyReads(input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                            input logic u1, input logic u2);
    A1D   = a1;
    A2D   = a2;
    Use1D = u1;
    Use2D = u2;
  endtask

  task automatic test_reset();
    resetModel();
    rst = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyReads(7, 31, 1, 1);
    #1;
    vectors++; if (RD1D !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_rd1: got %h want 0", RD1D); end
    vectors++; if (RD2D !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_rd2: got %h want 0", RD2D); end
    vectors++; if (BusyVec !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_busy: got %h want 0", BusyVec); end
    vectors++; if (StallD !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_stall: got %b want 0", StallD); end
    #1;
    rst = 1'b1;
  endtask

  task automatic test_write_read();
    applyStimulus(1, 7, 32'h0000_1234, 0, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyReads(7, 7, 0, 0);
    #1;
    vectors++; if (RD1D !== 32'h0000_1234) begin miscompares++; $display("[TB] FAIL write_read_rd1: got %h want 00001234", RD1D); end
    vectors++; if (RD2D !== RD1D || RD2D !== 32'h0000_1234) begin miscompares++; $display("[TB] FAIL write_read_rd2: got %h want 00001234", RD2D); end
  endtask

  task automatic test_x0();
    applyStimulus(1, 0, 32'hFFFF_FFFF, 1, 0, 0);
    applyReads(0, 0, 1, 1);
    #1;
    vectors++; if (RD1D !== 32'h0) begin miscompares++; $display("[TB] FAIL x0_same: got %h want 0", RD1D); end
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0);
    #1;
    vectors++; if (RD1D !== 32'h0) begin miscompares++; $display("[TB] FAIL x0_next: got %h want 0", RD1D); end
    vectors++; if (BusyVec !== 32'h0) begin miscompares++; $display("[TB] FAIL x0_busy: got %h want 0", BusyVec); end
    vectors++; if (StallD !== 1'b0) begin miscompares++; $display("[TB] FAIL x0_stall: got %b want 0", StallD); end
  endtask

  task automatic test_same_cycle();
    logic [XLEN-1:0] want;
    applyStimulus(1, 5, 32'h11, 0, 0, 0);
    tick();
    applyStimulus(1, 5, 32'hDEAD_BEEF, 0, 0, 0);
    applyReads(5, 5, 0, 0);
    #1;
    want = BYPASS ? 32'hDEAD_BEEF : 32'h11;
    vectors++; if (RD1D !== want) begin miscompares++; $display("[TB] FAIL same_cycle_rd1: got %h want %h", RD1D, want); end
    vectors++; if (RD2D !== want) begin miscompares++; $display("[TB] FAIL same_cycle_rd2: got %h want %h", RD2D, want); end
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0);
    #1;
    vectors++; if (RD1D !== 32'hDEAD_BEEF) begin miscompares++; $display("[TB] FAIL same_cycle_next: got %h want deadbeef", RD1D); end
  endtask

  task automatic test_load_use();
    logic want;
    applyStimulus(0, 0, 0, 1, 9, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyReads(9, 0, 1, 0);
    #1;
    vectors++; if (StallD !== 1'b1) begin miscompares++; $display("[TB] FAIL load_use_stall: got %b want 1", StallD); end
    vectors++; if (BusyVec[9] !== 1'b1) begin miscompares++; $display("[TB] FAIL load_use_busy: got %b want 1", BusyVec[9]); end
    tick();
    applyReads(0, 9, 0, 1);
    #1;
    vectors++; if (StallD !== 1'b1) begin miscompares++; $display("[TB] FAIL load_use_port2: got %b want 1", StallD); end
    applyReads(9, 0, 1, 0);
    applyStimulus(1, 9, 32'h9999, 0, 0, 0);
    #1;
    want = !BYPASS;
    vectors++; if (StallD !== want) begin miscompares++; $display("[TB] FAIL load_use_wb: got %b want %b", StallD, want); end
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0);
    #1;
    vectors++; if (StallD !== 1'b0) begin miscompares++; $display("[TB] FAIL load_use_after: got %b want 0", StallD); end
    vectors++; if (BusyVec[9] !== 1'b0) begin miscompares++; $display("[TB] FAIL load_use_clear: got %b want 0", BusyVec[9]); end
    vectors++; if (RD1D !== 32'h9999) begin miscompares++; $display("[TB] FAIL load_use_data: got %h want 00009999", RD1D); end
    // Same load but the source is not consumed: no stall at any point.
    applyStimulus(0, 0, 0, 1, 9, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyReads(9, 9, 0, 0);
    #1;
    vectors++; if (StallD !== 1'b0) begin miscompares++; $display("[TB] FAIL unused_src_stall: got %b want 0", StallD); end
    applyStimulus(1, 9, 32'h7, 0, 0, 0);
    #1;
    vectors++; if (StallD !== 1'b0) begin miscompares++; $display("[TB] FAIL unused_src_wb: got %b want 0", StallD); end
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_set_clear_flush();
    applyStimulus(1, 3, 32'h33, 1, 3, 0);
    tick();
    applyStimulus(0, 0, 0, 1, 4, 1);
    #1;
    vectors++; if (BusyVec[3] !== 1'b1) begin miscompares++; $display("[TB] FAIL set_wins: got %b want 1", BusyVec[3]); end
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0);
    #1;
    vectors++; if (BusyVec[4] !== 1'b0) begin miscompares++; $display("[TB] FAIL flush_blocks: got %b want 0", BusyVec[4]); end
    vectors++; if (BusyVec[3] !== 1'b1) begin miscompares++; $display("[TB] FAIL flush_keeps_old: got %b want 1", BusyVec[3]); end
    applyStimulus(1, 3, 32'h34, 0, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0);
    #1;
    vectors++; if (BusyVec !== 32'h0) begin miscompares++; $display("[TB] FAIL scoreboard_idle: got %h want 0", BusyVec); end
  endtask

  task automatic test_reset_mid();
    applyStimulus(1, 12, 32'hAB, 0, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 1, 12, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyReads(12, 12, 1, 0);
    #1;
    vectors++; if (BusyVec[12] !== 1'b1 || RD1D !== 32'hAB) begin miscompares++; $display("[TB] FAIL pre_reset: busy=%b rd=%h want 1/000000ab", BusyVec[12], RD1D); end
    #1;
    rst = 1'b0;
    resetModel();
    #1;
    vectors++; if (BusyVec !== 32'h0) begin miscompares++; $display("[TB] FAIL mid_reset_busy: got %h want 0", BusyVec); end
    vectors++; if (RD1D !== 32'h0) begin miscompares++; $display("[TB] FAIL mid_reset_rd: got %h want 0", RD1D); end
    vectors++; if (StallD !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_reset_stall: got %b want 0", StallD); end
    applyStimulus(1, 12, 32'h55, 1, 13, 0);
    #1;
    vectors++; if (RD1D !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_no_bypass: got %h want 0", RD1D); end
    tick();
    vectors++; if (RD1D !== 32'h0 || BusyVec !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_no_write: rd=%h busy=%h want 0/0", RD1D, BusyVec); end
    applyStimulus(0, 0, 0, 0, 0, 0);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      logic [AW-1:0] a1, a2, rw, re;
      a1 = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 31)) : AW'($urandom_range(0, 7));
      a2 = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 31)) : AW'($urandom_range(0, 7));
      rw = AW'($urandom_range(0, 7));
      re = AW'($urandom_range(0, 7));
      applyStimulus(1'($urandom_range(0, 1)), rw, $urandom,
                    ($urandom_range(0, 9) < 3), re, ($urandom_range(0, 9) < 2));
      applyReads(a1, a2, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      #1;
      vectors++; if (RD1D !== expRead(A1D)) begin miscompares++; $display("[TB] FAIL rand_rd1 #%0d: got %h want %h", n, RD1D, expRead(A1D)); end
      vectors++; if (RD2D !== expRead(A2D)) begin miscompares++; $display("[TB] FAIL rand_rd2 #%0d: got %h want %h", n, RD2D, expRead(A2D)); end
      vectors++; if (StallD !== expStall()) begin miscompares++; $display("[TB] FAIL rand_stall #%0d: got %b want %b", n, StallD, expStall()); end
      vectors++; if (BusyVec !== expBusyVec()) begin miscompares++; $display("[TB] FAIL rand_busy #%0d: got %h want %h", n, BusyVec, expBusyVec()); end
      tick();
    end
    applyStimulus(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_x0();
    test_same_cycle();
    test_load_use();
    test_set_clear_flush();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/decode_register_file.md
Name: decode_register_file

Overview:
- Integer register file on the consumer side of the writeback path.
- Accepts RegWriteW/RdW/ResultW from the writeback stage and serves the two decode-stage read ports.
- Adds a load scoreboard: registers with an outstanding load are marked busy, and decode is stalled until writeback retires them.
- Sits between writeback_cycle and decode_cycle; the hazard unit consumes StallD.

Parameters:
- XLEN, 32, data width of each register.
- NREG, 32, number of architectural registers; x0 included.
- AW, 5, register address width; must satisfy 2**AW == NREG.

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge.
- rst  input  1  asynchronous active-low reset.
- A1D  input  AW  read address, port 1 (rs1).
- A2D  input  AW  read address, port 2 (rs2).
- Use1D  input  1  rs1 is actually consumed by the decoding instruction.
- Use2D  input  1  rs2 is actually consumed by the decoding instruction.
- RD1D  output  XLEN  read data, port 1.
- RD2D  output  XLEN  read data, port 2.
- RegWriteW  input  1  writeback write enable.
- RdW  input  AW  writeback destination register.
- ResultW  input  XLEN  writeback data (output of the writeback result mux).
- LoadIssueE  input  1  a load has entered execute with destination RdE.
- RdE  input  AW  destination of the load in execute.
- FlushE  input  1  the execute-stage instruction is squashed this cycle.
- StallD  output  1  decode must hold; a consumed source register is busy.
- BusyVec  output  NREG  scoreboard state, for debug/verification.

Behaviour:
- Reset (rst=0, async): all NREG registers cleared to 0; BusyVec=0; StallD=0; RD1D/RD2D=0.
- While rst=0, writes and scoreboard updates are suppressed and bypass is forced off.
- Write:
  - On posedge clk, if RegWriteW=1 and RdW!=0, then reg[RdW] <= ResultW.
  - Writes to x0 are discarded; reg[0] reads 0 always.
- Read: combinational, zero-cycle latency.
  - RDnD = 0 if the address is 0.
  - Otherwise RDnD = reg[address], or the bypass value (see Optional Feature).
- Scoreboard update per clock edge, evaluated in this order:
  - Clear: if RegWriteW=1 and RdW!=0, then busy[RdW] <= 0.
  - Set: if LoadIssueE=1, FlushE=0 and RdE!=0, then busy[RdE] <= 1.
  - Set and clear to the same register in one cycle: set wins, because the new load is younger.
  - FlushE=1 blocks the set only. It does not cancel older busy bits.
  - busy[0] is never set.
- StallD (combinational) = (Use1D & busy[A1D]) | (Use2D & busy[A2D]).
  - Address 0 never stalls.
- Clear vs. StallD in the writeback cycle:
  - With bypass: a source being retired this cycle does not stall, i.e. the busy term is masked by the matching write.
  - Without bypass: it does stall for that cycle; the busy bit is cleared at the edge and the read is clean next cycle.
- Both read ports may address the same register; results are identical.
- Reset asserted mid-operation: all state is lost immediately; pending loads are forgotten.

Optional Feature:
- Macro: REGFILE_BYPASS_EN
- Defined:
  - Write-first forwarding: if RegWriteW=1, RdW!=0 and RdW==A1D, then RD1D=ResultW. Same rule for port 2.
  - The StallD busy term is masked for the register being written this cycle.
  - Effective read-after-write latency is 0 cycles.
- Undefined:
  - Reads return stored contents only.
  - A read of RdW in the same cycle returns the old value.
  - StallD stays asserted through the writeback cycle.
  - Effective read-after-write latency is 1 cycle.

Test Plan:
- Reset then read: rst=0 with A1D=7, A2D=31 -> RD1D=RD2D=0, BusyVec=0, StallD=0. Release rst, write x7=0x0000_1234 -> next cycle RD1D=0x0000_1234.
- x0 protection: RegWriteW=1, RdW=0, ResultW=0xFFFF_FFFF -> A1D=0 gives RD1D=0 in the same cycle and the next; no busy bit set.
- Same-cycle read of written register: RdW=5, ResultW=0xDEAD_BEEF, A1D=5, old x5=0x11.
  - Bypass on: RD1D=0xDEAD_BEEF in the same cycle.
  - Bypass off: RD1D=0x11 in that cycle, then 0xDEAD_BEEF next cycle.
- Load-use stall:
  - LoadIssueE=1, RdE=9. Next cycle A1D=9, Use1D=1 -> StallD=1.
  - Writeback RdW=9 later -> StallD=0 (bypass on: in the writeback cycle; bypass off: the cycle after). busy[9]=0 afterwards.
  - Same case with Use1D=0 -> StallD=0 throughout.
- Simultaneous set/clear and flush:
  - RegWriteW=1, RdW=3 with LoadIssueE=1, RdE=3 -> busy[3]=1 after the edge.
  - LoadIssueE=1, RdE=4, FlushE=1 -> busy[4] stays 0.
- Reset mid-operation: busy[12]=1 and x12=0xAB; assert rst asynchronously between clock edges -> BusyVec=0, RD for x12=0 immediately, without waiting for a clock edge.
